onehot_hold_decoder: RTL and testbench
======================================

Name: onehot_hold_decoder

Overview:
- Sequential companion on the receiving side of the priority encoder interface.
- Accepts an encoded index plus a valid flag (the encoder's y/z pair) and drives the matching one-hot line.
- The one-hot output is registered and held for a programmable number of cycles, then returns to zero.
- Issues ready/done handshakes so upstream logic knows when the next code can be sent.

Parameters:
- IN_W, 2, width of the encoded index; output width is 2**IN_W (derived localparam OUT_W).
- HOLD, 4, cycles the one-hot output stays asserted per accepted code; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable; low forces idle and zero output.
- x  input  IN_W  encoded index.
- z  input  1  index valid.
- ready  output  1  high when a new code can be accepted.
- y  output  OUT_W  registered one-hot output.
- done  output  1  single-cycle pulse on the last hold cycle.
- drop_cnt  output  8  dropped-request count (see Optional Feature).

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - state=IDLE, y=0, ready=0, done=0, hold counter=0, drop_cnt=0.
  - ready rises the first cycle after rst deasserts, provided en=1.
- ready = (state==IDLE) && en; it is combinational from registered state and en.
- Accept: the edge where z && ready.
  - Next cycle, y = 1<<x and state=HOLD.
  - Counter loads HOLD-1.
  - Latency is 1 cycle from accept to y.
- HOLD state:
  - y is held constant and the counter decrements each cycle.
  - x and z are ignored.
  - When counter==0, done=1 for that cycle.
  - On the next edge: state=IDLE, y=0.
  - y is therefore high for exactly HOLD cycles.
- Back-to-back:
  - ready returns 1 the cycle after done.
  - The minimum spacing between accepts is HOLD+1 cycles.
  - There is no same-cycle re-accept.
- HOLD=1: y is high for one cycle, and done coincides with that cycle.
- en low in HOLD: next edge gives state=IDLE, y=0, counter=0, and done is not pulsed (abort).
- en low in IDLE: ready=0, and z is ignored.
- rst during HOLD: same as power-on reset; it takes priority over en and z.
- x is always in range, because OUT_W=2**IN_W; there is no out-of-range case.
- State encoding: IDLE=0, HOLD=1, 1-bit register.

Optional Feature:
- Macro: DROP_CNT_EN.
- Defined:
  - drop_cnt increments on every edge where z=1 and ready=0 and rst=0.
  - It saturates at 255 and is cleared only by rst.
- Undefined: drop_cnt is tied to 0 and no counter logic is synthesised.
- Main datapath timing is identical in both builds.

Decomposition:
- Shared package (decoder_pkg):
  - state constants ST_IDLE and ST_HOLD.
  - default IN_W and HOLD values.
  - DROP_CNT_W=8 and DROP_CNT_MAX=255.
- One natural sub-module, hold_counter:
  - loadable down-counter.
  - inputs: load, load_val, dec, clr.
  - outputs: count, zero.
  - instantiated once for the hold timer.

Test Plan:
- Reset then accept: rst=1 for 2 cycles, then en=1, x=2, z=1 for one cycle.
  - Response: ready=1 before accept, y=4'b0100 from accept+1 for exactly 4 cycles.
  - done pulses on the 4th cycle, y=0 and ready=1 afterward.
- Sweep: HOLD=4, all x=0..3 back-to-back with z held 1.
  - Response: y sequences 0001, 0010, 0100, 1000, each for 4 cycles, separated by one idle cycle of y=0.
- Abort: accept x=3, then drop en on the 2nd hold cycle.
  - Response: y=0 next cycle, no done pulse, ready stays 0 until en=1.
- Reset mid-hold: accept x=1, assert rst on the 3rd hold cycle.
  - Response: y=0, done=0, drop_cnt=0 on the following cycle.
- HOLD=1 build: accept x=0.
  - Response: y=0001 for one cycle with done=1 in that same cycle; the next accept is possible 2 cycles after the first.
- DROP_CNT_EN defined: hold z=1 through a HOLD=4 transaction.
  - Response: drop_cnt=4 after it.
  - With z held for 300 busy cycles, drop_cnt saturates at 255.
  - Undefined build: drop_cnt stays 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and constants for the one-hot hold decoder and its hold timer.
package decoder_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam int DEF_IN_W   = 2;
   localparam int DEF_HOLD   = 4;
   localparam int HOLD_CNT_W = 8;

   localparam int                    DROP_CNT_W   = 8;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter used as the hold timer; clr wins over load, load over dec.
module hold_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/onehot_hold_decoder.sv
// Registered one-hot decoder that holds each accepted code for HOLD cycles.
// Optional dropped-request counter enabled by defining DROP_CNT_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | y=0; ready follows en; accepts a code when z && ready
//   ST_HOLD | y held; timer counts down; done on the last cycle; en low aborts
module onehot_hold_decoder
   import decoder_pkg::*;
#(
   parameter int IN_W = DEF_IN_W,
   parameter int HOLD = DEF_HOLD
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [IN_W-1:0]       x,
   input  logic                  z,
   output logic                  ready,
   output logic [(2**IN_W)-1:0]  y,
   output logic                  done,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam int                    OUT_W     = 2**IN_W;
   localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD - 1);

   state_t                  state_q, state_d;
   logic [OUT_W-1:0]        y_q, y_d;
   logic                    accept;
   logic                    cnt_load, cnt_dec, cnt_clr, cnt_zero;
   logic [HOLD_CNT_W-1:0]   cnt;

   assign ready  = (state_q == ST_IDLE) && en;
   assign accept = z && ready;
   // An en drop in the final hold cycle is an abort, so done is gated by en.
   assign done   = (state_q == ST_HOLD) && en && cnt_zero;
   assign y      = y_q;

   hold_counter #(
      .W (HOLD_CNT_W)
   ) u_hold_counter (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (HOLD_LOAD),
      .dec      (cnt_dec),
      .count    (cnt),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_clr  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d  = ST_HOLD;
               y_d      = OUT_W'(1) << x;
               cnt_load = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!en || cnt_zero) begin
               state_d = ST_IDLE;
               y_d     = '0;
               cnt_clr = 1'b1;
            end else begin
               cnt_dec = (cnt != '0);
            end
         end
      endcase
   end

`ifdef DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= '0;
      end else if (z && !ready && (drop_q != DROP_CNT_MAX)) begin
         drop_q <= drop_q + DROP_CNT_W'(1);
      end
   end

   assign drop_cnt = drop_q;
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_onehot_hold_decoder.sv
// Scoreboard bench for onehot_hold_decoder: HOLD=4 and HOLD=1 instances on shared inputs.
module tb_onehot_hold_decoder;

   logic       clk = 1'b0;
   logic       rst, en, z;
   logic [1:0] x;
   logic       ready4, done4, ready1, done1;
   logic [3:0] y4, y1;
   logic [7:0] drop4, drop1;

   always #5 clk = ~clk;

   onehot_hold_decoder #(.IN_W(2), .HOLD(4)) u_dut4 (
      .clk (clk), .rst (rst), .en (en), .x (x), .z (z),
      .ready (ready4), .y (y4), .done (done4), .drop_cnt (drop4)
   );

   onehot_hold_decoder #(.IN_W(2), .HOLD(1)) u_dut1 (
      .clk (clk), .rst (rst), .en (en), .x (x), .z (z),
      .ready (ready1), .y (y1), .done (done1), .drop_cnt (drop1)
   );

   typedef struct {
      logic [3:0] y;
      logic       done;
      logic       ready;
      bit         d1;
   } exp_t;

   exp_t  q[$];
   int    n_vec   = 0;
   int    n_err   = 0;
   int    m_drop4 = 0;
   int    m_drop1 = 0;
   string tag     = "init";

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
      n_vec++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s/%s got=%0h exp=%0h", tag, nm, got, want);
      end
   endtask

   task automatic push_exp(input logic [3:0] ey, input logic ed, input logic er, input bit d1);
      exp_t t;
      t.y = ey; t.done = ed; t.ready = er; t.d1 = d1;
      q.push_back(t);
   endtask

   // Drive one cycle's inputs at the falling edge, then check the oldest expectation.
   task automatic run(input logic r, input logic e, input logic zz, input logic [1:0] xx);
      exp_t t;
      @(negedge clk);
      rst = r; en = e; z = zz; x = xx;
      #1;
      n_vec++;
      assert (q.size() > 0) else begin
         n_err++;
         $error("FAIL %s/queue got=empty exp=entry", tag);
         return;
      end
      t = q.pop_front();
      if (!t.d1) begin
         chk("y",     8'(y4),     8'(t.y));
         chk("done",  8'(done4),  8'(t.done));
         chk("ready", 8'(ready4), 8'(t.ready));
         chk("drop",  drop4,      8'(m_drop4));
      end else begin
         chk("y1",     8'(y1),     8'(t.y));
         chk("done1",  8'(done1),  8'(t.done));
         chk("ready1", 8'(ready1), 8'(t.ready));
         chk("drop1",  drop1,      8'(m_drop1));
      end
      if (r) begin
         m_drop4 = 0;
         m_drop1 = 0;
      end
`ifdef DROP_CNT_EN
      else if (zz && !t.ready) begin
         if (t.d1) m_drop1 = (m_drop1 < 255) ? m_drop1 + 1 : 255;
         else      m_drop4 = (m_drop4 < 255) ? m_drop4 + 1 : 255;
      end
`endif
   endtask

   // Accept xi on the HOLD=4 instance, then four hold cycles with x scrambled and z=zh.
   task automatic txn(input logic [1:0] xi, input logic zh);
      push_exp(4'b0000, 1'b0, 1'b1, 1'b0);
      run(1'b0, 1'b1, 1'b1, xi);
      for (int k = 0; k < 4; k++) begin
         push_exp(4'(1) << xi, (k == 3), 1'b0, 1'b0);
         run(1'b0, 1'b1, zh, ~xi);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; z = 1'b0; x = 2'd0;
      @(posedge clk);

      tag = "reset";
      push_exp(4'b0000, 1'b0, 1'b0, 1'b0); run(1'b1, 1'b0, 1'b0, 2'd0);

      tag = "first";
      txn(2'd2, 1'b0);
      push_exp(4'b0000, 1'b0, 1'b1, 1'b0); run(1'b0, 1'b1, 1'b0, 2'd0);

      tag = "sweep";
      for (int xi = 0; xi < 4; xi++) txn(2'(xi), 1'b1);
      push_exp(4'b0000, 1'b0, 1'b1, 1'b0); run(1'b0, 1'b1, 1'b0, 2'd0);

      tag = "abort_mid";
      push_exp(4'b0000, 1'b0, 1'b1, 1'b0); run(1'b0, 1'b1, 1'b1, 2'd3);
      push_exp(4'b1000, 1'b0, 1'b0, 1'b0); run(1'b0, 1'b1, 1'b0, 2'd3);
      push_exp(4'b1000, 1'b0, 1'b0, 1'b0); run(1'b0, 1'b0, 1'b0, 2'd3);
      push_exp(4'b0000, 1'b0, 1'b0, 1'b0); run(1'b0, 1'b0, 1'b0, 2'd3);
      push_exp(4'b0000, 1'b0, 1'b0, 1'b0); run(1'b0, 1'b0, 1'b1, 2'd3);
      push_exp(4'b0000, 1'b0, 1'b1, 1'b0); run(1'b0, 1'b1, 1'b0, 2'd0);

      tag = "abort_last";
      push_exp(4'b0000, 1'b0, 1'b1, 1'b0); run(1'b0, 1'b1, 1'b1, 2'd0);
      for (int k = 0; k < 3; k++) begin
         push_exp(4'b0001, 1'b0, 1'b0, 1'b0); run(1'b0, 1'b1, 1'b0, 2'd0);
      end
      push_exp(4'b0001, 1'b0, 1'b0, 1'b0); run(1'b0, 1'b0, 1'b0, 2'd0);
      push_exp(4'b0000, 1'b0, 1'b1, 1'b0); run(1'b0, 1'b1, 1'b0, 2'd0);

      tag = "rst_mid";
      push_exp(4'b0000, 1'b0, 1'b1, 1'b0); run(1'b0, 1'b1, 1'b1, 2'd1);
      push_exp(4'b0010, 1'b0, 1'b0, 1'b0); run(1'b0, 1'b1, 1'b0, 2'd1);
      push_exp(4'b0010, 1'b0, 1'b0, 1'b0); run(1'b0, 1'b1, 1'b0, 2'd1);
      push_exp(4'b0010, 1'b0, 1'b0, 1'b0); run(1'b1, 1'b1, 1'b0, 2'd1);
      push_exp(4'b0000, 1'b0, 1'b1, 1'b0); run(1'b0, 1'b1, 1'b0, 2'd0);

      tag = "saturate";
      for (int k = 0; k < 300; k++) begin
         push_exp(4'b0000, 1'b0, 1'b0, 1'b0); run(1'b0, 1'b0, 1'b1, 2'd0);
      end
      push_exp(4'b0000, 1'b0, 1'b0, 1'b0); run(1'b0, 1'b0, 1'b0, 2'd0);
      push_exp(4'b0000, 1'b0, 1'b0, 1'b0); run(1'b1, 1'b0, 1'b0, 2'd0);
      push_exp(4'b0000, 1'b0, 1'b0, 1'b0); run(1'b0, 1'b0, 1'b0, 2'd0);

      tag = "hold1";
      push_exp(4'b0000, 1'b0, 1'b1, 1'b1); run(1'b0, 1'b1, 1'b1, 2'd0);
      push_exp(4'b0001, 1'b1, 1'b0, 1'b1); run(1'b0, 1'b1, 1'b1, 2'd0);
      push_exp(4'b0000, 1'b0, 1'b1, 1'b1); run(1'b0, 1'b1, 1'b1, 2'd0);
      push_exp(4'b0001, 1'b1, 1'b0, 1'b1); run(1'b0, 1'b1, 1'b0, 2'd0);
      push_exp(4'b0000, 1'b0, 1'b1, 1'b1); run(1'b0, 1'b1, 1'b0, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
